// File: rtl/speed_pkg.sv
// Shared constants for the speed stepping path: FSM state codes, step
// direction codes and the default board timing used by the counter and
// display blocks.
package speed_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RPT  = 2'd3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_SPD_MIN    = 0;
    localparam int DEF_SPD_MAX    = 15;
    localparam int DEF_DEB_CYCLES = 500000;
    localparam int DEF_RPT_DELAY  = 25000000;
    localparam int DEF_RPT_PERIOD = 5000000;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int cnt_bits(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stable-sample
// debounce counter and a one-cycle press pulse on the released->pressed
// transition of the debounced level.
module key_debounce
    import speed_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic press_o
);

    localparam int CW = cnt_bits(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          prs_q, prs_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample equal to the current level restarts the stable run.
    always_comb begin
        lvl_d = lvl_q;
        prs_d = 1'b0;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == LAST) begin
                lvl_d = s2_q;
                prs_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state; everything resets to "released".
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            lvl_q <= 1'b1;
            prs_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= key_ni;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            prs_q <= prs_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign press_o = prs_q;

endmodule

// File: rtl/speed_step_ctrl.sv
// Speed step controller: turns Key2 (faster) / Key1 (slower) presses into
// single-cycle ENABLE/UP_DOWN strobes and keeps a saturating shadow of the
// speed level. Define SPEED_STEP_AUTOREPEAT_EN to make a held key repeat.
module speed_step_ctrl
    import speed_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SPD_MIN    = DEF_SPD_MIN,
    parameter int SPD_MAX    = DEF_SPD_MAX,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Key1,
    input  logic             Key2,
    output logic             ENABLE,
    output logic             UP_DOWN,
    output logic [WIDTH-1:0] SPEED,
    output logic             AT_MIN,
    output logic             AT_MAX
);

    localparam logic [WIDTH-1:0] MINV = WIDTH'(SPD_MIN);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(SPD_MAX);

    logic k1_lvl, k1_prs, k2_lvl, k2_prs;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key1 (
        .clk_i(CLK), .rst_ni(RSTn), .key_ni(Key1), .level_o(k1_lvl), .press_o(k1_prs)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key2 (
        .clk_i(CLK), .rst_ni(RSTn), .key_ni(Key2), .level_o(k2_lvl), .press_o(k2_prs)
    );

    logic [1:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic             blk_q, blk_d;
    logic             en_q, en_d;
    logic             ud_q, ud_d;
    logic [WIDTH-1:0] spd_q, spd_d;
    logic             amin_q, amin_d;
    logic             amax_q, amax_d;
    logic             held_rel;

    // Debounced level of whichever key owns the current hold.
    assign held_rel = (dir_q == DIR_DN) ? k1_lvl : k2_lvl;

`ifdef SPEED_STEP_AUTOREPEAT_EN
    localparam int TW = cnt_bits((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PERIOD - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          rpt_q, rpt_d;

    // Hold timer runs only while waiting; the step cycle clears it.
    assign tmr_d = (state_q == S_WAIT || state_q == S_RPT) ? tmr_q + 1'b1 : '0;

    // Repeat timer and "next step is a repeat" flag.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            tmr_q <= '0;
            rpt_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            rpt_q <= rpt_d;
        end
    end
`else
    // Repeat timing parameters have no effect when repeat is compiled out.
    logic [31:0] unused_rpt;
    assign unused_rpt = 32'(RPT_DELAY ^ RPT_PERIOD);
`endif

    // Next-state: key arbitration, blocking of two-key presses, hold/repeat.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        blk_d   = blk_q;
`ifdef SPEED_STEP_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (blk_q) begin
                    if (k1_lvl && k2_lvl) blk_d = 1'b0;
                end else if (k1_prs && k2_prs) begin
                    blk_d = 1'b1;
                end else if (k1_prs) begin
                    if (!k2_lvl) blk_d = 1'b1;
                    else begin
                        dir_d   = DIR_DN;
                        state_d = S_STEP;
`ifdef SPEED_STEP_AUTOREPEAT_EN
                        rpt_d   = 1'b0;
`endif
                    end
                end else if (k2_prs) begin
                    if (!k1_lvl) blk_d = 1'b1;
                    else begin
                        dir_d   = DIR_UP;
                        state_d = S_STEP;
`ifdef SPEED_STEP_AUTOREPEAT_EN
                        rpt_d   = 1'b0;
`endif
                    end
                end
            end
            S_STEP: begin
`ifdef SPEED_STEP_AUTOREPEAT_EN
                state_d = rpt_q ? S_RPT : S_WAIT;
`else
                state_d = S_WAIT;
`endif
            end
            S_WAIT: begin
                if (held_rel) state_d = S_IDLE;
`ifdef SPEED_STEP_AUTOREPEAT_EN
                else if (tmr_q == DLY_LAST) begin
                    state_d = S_STEP;
                    rpt_d   = 1'b1;
                end
`endif
            end
            S_RPT: begin
`ifdef SPEED_STEP_AUTOREPEAT_EN
                if (held_rel) state_d = S_IDLE;
                else if (tmr_q == PER_LAST) begin
                    state_d = S_STEP;
                    rpt_d   = 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered on entry to S_STEP so the strobe and the new
    // speed appear together; an out-of-range step is silently dropped.
    always_comb begin
        en_d  = 1'b0;
        ud_d  = ud_q;
        spd_d = spd_q;
        if (state_d == S_STEP) begin
            if (dir_d == DIR_UP && spd_q < MAXV) begin
                en_d  = 1'b1;
                ud_d  = DIR_UP;
                spd_d = spd_q + 1'b1;
            end else if (dir_d == DIR_DN && spd_q > MINV) begin
                en_d  = 1'b1;
                ud_d  = DIR_DN;
                spd_d = spd_q - 1'b1;
            end
        end
        amin_d = (spd_d == MINV);
        amax_d = (spd_d == MAXV);
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            blk_q   <= 1'b0;
            en_q    <= 1'b0;
            ud_q    <= DIR_UP;
            spd_q   <= MINV;
            amin_q  <= 1'b1;
            amax_q  <= (MINV == MAXV);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            blk_q   <= blk_d;
            en_q    <= en_d;
            ud_q    <= ud_d;
            spd_q   <= spd_d;
            amin_q  <= amin_d;
            amax_q  <= amax_d;
        end
    end

    assign ENABLE  = en_q;
    assign UP_DOWN = ud_q;
    assign SPEED   = spd_q;
    assign AT_MIN  = amin_q;
    assign AT_MAX  = amax_q;

endmodule

// File: tb/tb_speed_step_ctrl.sv
// Bench for speed_step_ctrl: directed scenarios plus random key traffic,
// all compared each cycle against a behavioural model of the key rules.
module tb_speed_step_ctrl;

    localparam int WIDTH = 4, SPD_MIN = 0, SPD_MAX = 3;
    localparam int DEB = 4, RPT_DELAY = 20, RPT_PERIOD = 5;
`ifdef SPEED_STEP_AUTOREPEAT_EN
    localparam bit AUTORPT = 1'b1;
`else
    localparam bit AUTORPT = 1'b0;
`endif

    logic CLK = 1'b0, RSTn = 1'b0, Key1 = 1'b1, Key2 = 1'b1;
    logic ENABLE, UP_DOWN, AT_MIN, AT_MAX;
    logic [WIDTH-1:0] SPEED;
    logic [7:0] obs;
    assign obs = {ENABLE, UP_DOWN, SPEED, AT_MIN, AT_MAX};

    speed_step_ctrl #(
        .WIDTH(WIDTH), .SPD_MIN(SPD_MIN), .SPD_MAX(SPD_MAX),
        .DEB_CYCLES(DEB), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Key1(Key1), .Key2(Key2),
        .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .SPEED(SPEED),
        .AT_MIN(AT_MIN), .AT_MAX(AT_MAX)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, cyc = 0;

    // Behavioural model. Keys indexed 0 = Key1 (slower), 1 = Key2 (faster).
    bit m_s1[2], m_s2[2], m_lvl[2], m_prs[2];
    int m_run[2];
    bit m_busy, m_blk, m_en, m_ud;
    int m_held, m_since, m_gap, m_spd;

    function automatic void model_edge(input bit rst_n, input bit k1, input bit k2);
        bit stp;
        bit raw[2];
        raw[0] = k1; raw[1] = k2;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1; m_prs[k] = 0; m_run[k] = 0;
            end
            m_busy = 0; m_blk = 0; m_en = 0; m_ud = 0; m_spd = SPD_MIN;
            return;
        end
        stp  = 0;
        m_en = 0;
        if (!m_busy) begin
            if (m_blk) begin
                if (m_lvl[0] && m_lvl[1]) m_blk = 0;
            end else if (m_prs[0] && m_prs[1]) begin
                m_blk = 1;
            end else if (m_prs[0] || m_prs[1]) begin
                int k = m_prs[0] ? 0 : 1;
                if (!m_lvl[1-k]) m_blk = 1;
                else begin m_held = k; m_busy = 1; stp = 1; m_gap = RPT_DELAY; end
            end
        end else begin
            m_since++;
            if (m_since > 1) begin
                if (m_lvl[m_held]) m_busy = 0;
                else if (AUTORPT && m_since == m_gap + 1) begin stp = 1; m_gap = RPT_PERIOD; end
            end
        end
        if (stp) begin
            m_since = 0;
            if (m_held == 1 && m_spd < SPD_MAX) begin m_spd++; m_en = 1; m_ud = 0; end
            else if (m_held == 0 && m_spd > SPD_MIN) begin m_spd--; m_en = 1; m_ud = 1; end
        end
        // Key conditioning: level flips after DEB consecutive differing samples.
        for (int k = 0; k < 2; k++) begin
            m_prs[k] = 0;
            if (m_s2[k] != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_lvl[k] = m_s2[k]; m_prs[k] = !m_s2[k]; m_run[k] = 0;
                end
            end else m_run[k] = 0;
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
    endfunction

    function automatic logic [7:0] exp_vec();
        return {m_en, m_ud, 4'(m_spd), m_spd == SPD_MIN, m_spd == SPD_MAX};
    endfunction

    // One clock: model follows the edge, DUT is sampled on the falling edge.
    task automatic step();
        @(posedge CLK);
        model_edge(RSTn, Key1, Key2);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTn = 0; Key1 = 1; Key2 = 1;
        step();
        RSTn = 1;
    endtask

    task automatic test_reset();
        RSTn = 0; Key1 = 0; Key2 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) RSTn = 1;
            step();
            checks++;
            if ({ENABLE, SPEED, AT_MIN, AT_MAX} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state i=%0d got=%b exp=%b", i, {ENABLE, SPEED, AT_MIN, AT_MAX}, 7'b0000010);
            end
        end
        for (int i = 0; i < 22; i++) begin
            if (i == 14) begin Key1 = 1; Key2 = 1; end
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_single_step();
        int n = 0, t_en = -1;
        logic ud = 1'bx;
        Key2 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) Key2 = 1;
            step();
            if (ENABLE) begin n++; t_en = t; ud = UP_DOWN; end
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL single_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (n !== 1 || t_en !== 7 || ud !== 1'b0 || SPEED !== 4'd1) begin
            errors++;
            $display("FAIL single_step got n=%0d t=%0d ud=%b spd=%0d exp n=1 t=7 ud=0 spd=1", n, t_en, ud, SPEED);
        end
    endtask

    task automatic test_hold_repeat();
        int got_t[$];
        int exp_t[$];
        if (AUTORPT) exp_t = '{7, 28, 34}; else exp_t = '{7};
        do_reset();
        Key2 = 0;
        for (int t = 1; t <= 70; t++) begin
            if (t == 61) Key2 = 1;
            step();
            if (ENABLE) got_t.push_back(t);
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL hold_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (got_t.size() != exp_t.size()) begin
            errors++; $display("FAIL hold_count got=%0d exp=%0d", got_t.size(), exp_t.size());
        end
        for (int i = 0; i < exp_t.size() && i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] != exp_t[i]) begin
                errors++; $display("FAIL hold_time idx=%0d got=%0d exp=%0d", i, got_t[i], exp_t[i]);
            end
        end
        checks++;
        if (SPEED !== (AUTORPT ? 4'd3 : 4'd1) || AT_MAX !== AUTORPT) begin
            errors++; $display("FAIL hold_sat got spd=%0d atmax=%b exp spd=%0d atmax=%b",
                               SPEED, AT_MAX, AUTORPT ? 3 : 1, AUTORPT);
        end
    endtask

    task automatic test_min_tap();
        int n = 0;
        do_reset();
        Key1 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) Key1 = 1;
            step();
            if (ENABLE) n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL mintap_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (n !== 0 || SPEED !== 4'd0 || AT_MIN !== 1'b1) begin
            errors++; $display("FAIL min_tap got n=%0d spd=%0d exp n=0 spd=0", n, SPEED);
        end
    endtask

    task automatic test_bounce();
        int n = 0;
        logic ud = 1'bx;
        Key2 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) Key2 = 1;
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bounce_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        for (int t = 1; t <= 25; t++) begin
            Key1 = (t == 2 || t >= 16) ? 1'b1 : 1'b0;
            step();
            if (ENABLE) begin n++; ud = UP_DOWN; end
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL bounce_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (n !== 1 || ud !== 1'b1 || SPEED !== 4'd0) begin
            errors++; $display("FAIL bounce got n=%0d ud=%b spd=%0d exp n=1 ud=1 spd=0", n, ud, SPEED);
        end
    endtask

    task automatic test_both_keys();
        int n = 0;
        Key1 = 0; Key2 = 0;
        for (int t = 1; t <= 45; t++) begin
            if (t == 16) Key1 = 1;
            if (t == 26) Key2 = 1;
            step();
            if (ENABLE) n++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL both_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL both_blocked got n=%0d exp n=0", n); end
        Key2 = 0;
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) Key2 = 1;
            step();
            if (ENABLE) n++;
        end
        checks++;
        if (n !== 1 || SPEED !== 4'd1) begin
            errors++; $display("FAIL both_after got n=%0d spd=%0d exp n=1 spd=1", n, SPEED);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n = 0, t_en = -1;
        do_reset();
        Key2 = 0;
        for (int t = 1; t <= 31; t++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
        end
        RSTn = 0; Key2 = 1;
        step();
        RSTn = 1;
        checks++;
        if ({ENABLE, SPEED, AT_MIN} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL midrst_state got en=%b spd=%0d amin=%b exp en=0 spd=0 amin=1", ENABLE, SPEED, AT_MIN);
        end
        for (int t = 1; t <= 30; t++) begin
            step();
            if (ENABLE) n++;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL midrst_quiet got n=%0d exp n=0", n); end
        Key2 = 0;
        for (int t = 1; t <= 10; t++) begin
            step();
            if (ENABLE) begin n++; t_en = t; end
        end
        Key2 = 1;
        checks++;
        if (n !== 1 || t_en !== 7 || SPEED !== 4'd1) begin
            errors++; $display("FAIL midrst_fresh got n=%0d t=%0d spd=%0d exp n=1 t=7 spd=1", n, t_en, SPEED);
        end
    endtask

    task automatic test_random();
        logic prev_en = 1'b0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) Key1 = ~Key1;
            if ($urandom_range(0, 11) == 0) Key2 = ~Key2;
            RSTn = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random_lockstep cyc=%0d got=%b exp=%b", cyc, obs, exp_vec());
            end
            checks++;
            if (prev_en && ENABLE) begin
                errors++; $display("FAIL random_double_enable cyc=%0d got=11 exp=not both", cyc);
            end
            prev_en = ENABLE;
        end
        RSTn = 1;
    endtask

    initial begin
        model_edge(1'b0, 1'b1, 1'b1);
        @(negedge CLK);
        test_reset();
        test_single_step();
        test_hold_repeat();
        test_min_tap();
        test_bounce();
        test_both_keys();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
